// File: rtl/axi_master_arbiter.sv
// N-to-1 AXI4 master arbiter: independent round-robin AR/AW grants, W locked to the
// AW winner, and master index prefixed onto IDs so R/B responses route back directly.
module axi_master_arbiter #(
    parameter int N_MST  = 2,
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int IDX_W  = $clog2(N_MST)
) (
    input  logic                          clock,
    input  logic                          reset,

    input  logic [N_MST*ID_W-1:0]         s_awid,
    input  logic [N_MST*ADDR_W-1:0]       s_awaddr,
    input  logic [N_MST*8-1:0]            s_awlen,
    input  logic [N_MST*3-1:0]            s_awsize,
    input  logic [N_MST*2-1:0]            s_awburst,
    input  logic [N_MST-1:0]              s_awvalid,
    output logic [N_MST-1:0]              s_awready,

    input  logic [N_MST*DATA_W-1:0]       s_wdata,
    input  logic [N_MST*(DATA_W/8)-1:0]   s_wstrb,
    input  logic [N_MST-1:0]              s_wlast,
    input  logic [N_MST-1:0]              s_wvalid,
    output logic [N_MST-1:0]              s_wready,

    output logic [N_MST*ID_W-1:0]         s_bid,
    output logic [N_MST*2-1:0]            s_bresp,
    output logic [N_MST-1:0]              s_bvalid,
    input  logic [N_MST-1:0]              s_bready,

    input  logic [N_MST*ID_W-1:0]         s_arid,
    input  logic [N_MST*ADDR_W-1:0]       s_araddr,
    input  logic [N_MST*8-1:0]            s_arlen,
    input  logic [N_MST*3-1:0]            s_arsize,
    input  logic [N_MST*2-1:0]            s_arburst,
    input  logic [N_MST-1:0]              s_arvalid,
    output logic [N_MST-1:0]              s_arready,

    output logic [N_MST*ID_W-1:0]         s_rid,
    output logic [N_MST*DATA_W-1:0]       s_rdata,
    output logic [N_MST*2-1:0]            s_rresp,
    output logic [N_MST-1:0]              s_rlast,
    output logic [N_MST-1:0]              s_rvalid,
    input  logic [N_MST-1:0]              s_rready,

    output logic [ID_W+IDX_W-1:0]         m_awid,
    output logic [ADDR_W-1:0]             m_awaddr,
    output logic [7:0]                    m_awlen,
    output logic [2:0]                    m_awsize,
    output logic [1:0]                    m_awburst,
    output logic                          m_awvalid,
    input  logic                          m_awready,

    output logic [DATA_W-1:0]             m_wdata,
    output logic [DATA_W/8-1:0]           m_wstrb,
    output logic                          m_wlast,
    output logic                          m_wvalid,
    input  logic                          m_wready,

    input  logic [ID_W+IDX_W-1:0]         m_bid,
    input  logic [1:0]                    m_bresp,
    input  logic                          m_bvalid,
    output logic                          m_bready,

    output logic [ID_W+IDX_W-1:0]         m_arid,
    output logic [ADDR_W-1:0]             m_araddr,
    output logic [7:0]                    m_arlen,
    output logic [2:0]                    m_arsize,
    output logic [1:0]                    m_arburst,
    output logic                          m_arvalid,
    input  logic                          m_arready,

    input  logic [ID_W+IDX_W-1:0]         m_rid,
    input  logic [DATA_W-1:0]             m_rdata,
    input  logic [1:0]                    m_rresp,
    input  logic                          m_rlast,
    input  logic                          m_rvalid,
    output logic                          m_rready,

    output logic                          decode_err
);

    localparam int MID_W  = ID_W + IDX_W;
    localparam int STRB_W = DATA_W / 8;
    localparam logic [IDX_W:0] N_MST_L = (IDX_W+1)'(N_MST);

    // Returns {found, index} of the first requester at or after ptr, wrapping modulo N_MST.
    function automatic logic [IDX_W:0] rr_pick(input logic [N_MST-1:0] req,
                                               input logic [IDX_W-1:0] ptr);
        logic [IDX_W:0]   res;
        logic [IDX_W-1:0] jj;
        int               j;
        res = '0;
        for (int k = N_MST - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= N_MST) j = j - N_MST;
            jj = j[IDX_W-1:0];
            if (req[jj]) res = {1'b1, jj};
        end
        return res;
    endfunction

    function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] cur);
        return ({1'b0, cur} == N_MST_L - 1'b1) ? '0 : cur + 1'b1;
    endfunction

    typedef enum logic {AR_IDLE, AR_LOCK} ar_state_t;
    typedef enum logic {W_IDLE, W_BUSY} w_state_t;

    ar_state_t        ar_state, ar_state_nx;
    logic [IDX_W-1:0] rr_ar, ar_lock_idx, ar_sel, ar_win;
    logic             ar_found, ar_grant, ar_hs;

    w_state_t         w_state, w_state_nx;
    logic [IDX_W-1:0] rr_aw, widx, w_sel, aw_win;
    logic             aw_found, w_grant, w_open, aw_done, w_done, aw_hs, wl_hs, busy;

    logic [IDX_W-1:0] r_idx, b_idx;
    logic             r_ok, b_ok, r_sel_rdy, b_sel_rdy;

    assign {ar_found, ar_win} = rr_pick(s_arvalid, rr_ar);
    assign {aw_found, aw_win} = rr_pick(s_awvalid, rr_aw);

    // Read address: the lock index keeps an unaccepted request stable under backpressure.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ar_state    <= AR_IDLE;
            rr_ar       <= '0;
            ar_lock_idx <= '0;
        end else begin
            ar_state <= ar_state_nx;
            if (ar_state == AR_IDLE && ar_found) ar_lock_idx <= ar_win;
            if (ar_hs) rr_ar <= rr_next(ar_sel);
        end
    end

    always_comb begin
        ar_state_nx = ar_state;
        case (ar_state)
            AR_IDLE: if (ar_grant && !ar_hs) ar_state_nx = AR_LOCK;
            AR_LOCK: if (ar_hs) ar_state_nx = AR_IDLE;
            default: ar_state_nx = AR_IDLE;
        endcase
    end

    always_comb begin
        ar_sel    = (ar_state == AR_LOCK) ? ar_lock_idx : ar_win;
        ar_grant  = reset && ((ar_state == AR_LOCK) || ar_found);
        m_arvalid = ar_grant && s_arvalid[ar_sel];
        ar_hs     = m_arvalid && m_arready;
        s_arready = '0;
        if (ar_grant) s_arready[ar_sel] = m_arready;
        m_arid    = {ar_sel, s_arid[int'(ar_sel)*ID_W +: ID_W]};
        m_araddr  = s_araddr[int'(ar_sel)*ADDR_W +: ADDR_W];
        m_arlen   = s_arlen[int'(ar_sel)*8 +: 8];
        m_arsize  = s_arsize[int'(ar_sel)*3 +: 3];
        m_arburst = s_arburst[int'(ar_sel)*2 +: 2];
    end

    // Write path: one burst owns both AW and W until its address and last beat are accepted.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            w_state <= W_IDLE;
            rr_aw   <= '0;
            widx    <= '0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            w_state <= w_state_nx;
            aw_done <= (w_state_nx == W_BUSY) && (aw_done || aw_hs);
            w_done  <= (w_state_nx == W_BUSY) && (w_done || wl_hs);
            if (w_state == W_IDLE && aw_found) begin
                widx  <= aw_win;
                rr_aw <= rr_next(aw_win);
            end
        end
    end

    always_comb begin
        w_state_nx = w_state;
        case (w_state)
            W_IDLE:  if (w_grant && !(aw_hs && wl_hs)) w_state_nx = W_BUSY;
            W_BUSY:  if ((aw_done || aw_hs) && (w_done || wl_hs)) w_state_nx = W_IDLE;
            default: w_state_nx = W_IDLE;
        endcase
    end

    always_comb begin
        busy      = (w_state == W_BUSY);
        w_sel     = busy ? widx : aw_win;
        w_grant   = reset && (busy || aw_found);
        w_open    = w_grant && !w_done;
        m_awid    = {w_sel, s_awid[int'(w_sel)*ID_W +: ID_W]};
        m_awaddr  = s_awaddr[int'(w_sel)*ADDR_W +: ADDR_W];
        m_awlen   = s_awlen[int'(w_sel)*8 +: 8];
        m_awsize  = s_awsize[int'(w_sel)*3 +: 3];
        m_awburst = s_awburst[int'(w_sel)*2 +: 2];
        m_wdata   = s_wdata[int'(w_sel)*DATA_W +: DATA_W];
        m_wstrb   = s_wstrb[int'(w_sel)*STRB_W +: STRB_W];
        m_wlast   = s_wlast[w_sel];
        m_awvalid = w_grant && !aw_done && s_awvalid[w_sel];
        m_wvalid  = w_open && s_wvalid[w_sel];
        aw_hs     = m_awvalid && m_awready;
        wl_hs     = m_wvalid && m_wready && m_wlast;
        s_awready = '0;
        if (w_grant && !aw_done) s_awready[w_sel] = m_awready;
        s_wready  = '0;
        if (w_open) s_wready[w_sel] = m_wready;
    end

    // Responses: the ID prefix selects the upstream lane; unknown indices are drained.
    always_comb begin
        r_idx     = m_rid[MID_W-1:ID_W];
        b_idx     = m_bid[MID_W-1:ID_W];
        r_ok      = {1'b0, r_idx} < N_MST_L;
        b_ok      = {1'b0, b_idx} < N_MST_L;
        r_sel_rdy = 1'b0;
        b_sel_rdy = 1'b0;
        s_rvalid  = '0;
        s_bvalid  = '0;
        for (int i = 0; i < N_MST; i++) begin
            if (r_idx == IDX_W'(i)) begin
                r_sel_rdy   = s_rready[i];
                s_rvalid[i] = reset && m_rvalid;
            end
            if (b_idx == IDX_W'(i)) begin
                b_sel_rdy   = s_bready[i];
                s_bvalid[i] = reset && m_bvalid;
            end
        end
        m_rready = reset && (r_ok ? r_sel_rdy : 1'b1);
        m_bready = reset && (b_ok ? b_sel_rdy : 1'b1);
        s_rid    = {N_MST{m_rid[ID_W-1:0]}};
        s_rdata  = {N_MST{m_rdata}};
        s_rresp  = {N_MST{m_rresp}};
        s_rlast  = {N_MST{m_rlast}};
        s_bid    = {N_MST{m_bid[ID_W-1:0]}};
        s_bresp  = {N_MST{m_bresp}};
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            decode_err <= 1'b0;
        else if ((m_rvalid && !r_ok) || (m_bvalid && !b_ok))
            decode_err <= 1'b1;
    end

endmodule

// File: tb/tb_axi_master_arbiter.sv
// Randomized bench for axi_master_arbiter (N_MST=5) against a grant/ownership model.
module tb_axi_master_arbiter;

    localparam int N      = 5;
    localparam int ID_W   = 4;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int IDX_W  = 3;
    localparam int MID_W  = ID_W + IDX_W;
    localparam int STRB_W = DATA_W / 8;

    logic clock = 1'b0;
    logic reset = 1'b0;

    logic [N*ID_W-1:0]   s_awid, s_arid, s_bid, s_rid;
    logic [N*ADDR_W-1:0] s_awaddr, s_araddr;
    logic [N*8-1:0]      s_awlen, s_arlen;
    logic [N*3-1:0]      s_awsize, s_arsize;
    logic [N*2-1:0]      s_awburst, s_arburst, s_bresp, s_rresp;
    logic [N-1:0]        s_awvalid, s_awready, s_wlast, s_wvalid, s_wready;
    logic [N-1:0]        s_bvalid, s_bready, s_arvalid, s_arready, s_rlast, s_rvalid, s_rready;
    logic [N*DATA_W-1:0] s_wdata, s_rdata;
    logic [N*STRB_W-1:0] s_wstrb;

    logic [MID_W-1:0]    m_awid, m_bid, m_arid, m_rid;
    logic [ADDR_W-1:0]   m_awaddr, m_araddr;
    logic [7:0]          m_awlen, m_arlen;
    logic [2:0]          m_awsize, m_arsize;
    logic [1:0]          m_awburst, m_arburst, m_bresp, m_rresp;
    logic                m_awvalid, m_awready, m_wlast, m_wvalid, m_wready;
    logic                m_bvalid, m_bready, m_arvalid, m_arready, m_rlast, m_rvalid, m_rready;
    logic [DATA_W-1:0]   m_wdata, m_rdata;
    logic [STRB_W-1:0]   m_wstrb;
    logic                decode_err;

    axi_master_arbiter #(.N_MST(N), .ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .IDX_W(IDX_W)) dut (
        .clock(clock), .reset(reset),
        .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize),
        .s_awburst(s_awburst), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
        .s_arburst(s_arburst), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
        .s_rvalid(s_rvalid), .s_rready(s_rready),
        .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
        .m_awburst(m_awburst), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
        .m_arburst(m_arburst), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
        .m_rvalid(m_rvalid), .m_rready(m_rready),
        .decode_err(decode_err)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    // Reference model: who owns each channel, the rotating pointers, and upstream master state.
    int rr_ar_m, ar_g, rr_aw_m, wg;
    bit aw_d, w_d, dec_m;
    bit ar_hs_p [N];
    bit aw_hs_p [N];
    bit w_hs_p  [N];
    int w_left  [N];

    task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pick(input logic [N-1:0] req, input int ptr);
        for (int k = 0; k < N; k++)
            if (req[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    task automatic drive_idle();
        s_awid = '0; s_awaddr = '0; s_awlen = '0; s_awsize = '0; s_awburst = '0; s_awvalid = '0;
        s_wdata = '0; s_wstrb = '0; s_wlast = '0; s_wvalid = '0; s_bready = '0;
        s_arid = '0; s_araddr = '0; s_arlen = '0; s_arsize = '0; s_arburst = '0; s_arvalid = '0;
        s_rready = '0;
        m_awready = 0; m_wready = 0; m_arready = 0;
        m_bid = '0; m_bresp = '0; m_bvalid = 0;
        m_rid = '0; m_rdata = '0; m_rresp = '0; m_rlast = 0; m_rvalid = 0;
    endtask

    task automatic model_reset();
        rr_ar_m = 0; ar_g = -1; rr_aw_m = 0; wg = -1; aw_d = 0; w_d = 0; dec_m = 0;
        for (int i = 0; i < N; i++) begin
            ar_hs_p[i] = 0; aw_hs_p[i] = 0; w_hs_p[i] = 0; w_left[i] = 0;
        end
    endtask

    function automatic logic [MID_W-1:0] rand_resp_id();
        int idx;
        idx = ($urandom_range(0, 63) == 0) ? int'($urandom_range(N, 7)) : int'($urandom_range(0, N-1));
        return {3'(idx), 4'($urandom)};
    endfunction

    // Upstream masters keep valid stable until accepted; downstream readies toggle freely.
    task automatic apply_stimulus();
        for (int i = 0; i < N; i++) begin
            if (ar_hs_p[i]) s_arvalid[i] = 0;
            if (!s_arvalid[i] && $urandom_range(0, 3) == 0) begin
                s_arvalid[i] = 1;
                s_arid[i*ID_W +: ID_W] = 4'($urandom);
                s_araddr[i*ADDR_W +: ADDR_W] = $urandom;
                s_arlen[i*8 +: 8] = 8'($urandom);
            end
            if (aw_hs_p[i]) s_awvalid[i] = 0;
            if (w_hs_p[i]) begin
                s_wvalid[i] = 0;
                w_left[i]--;
            end
            if (!s_awvalid[i] && w_left[i] == 0 && $urandom_range(0, 3) == 0) begin
                s_awvalid[i] = 1;
                s_awlen[i*8 +: 8] = 8'($urandom_range(0, 3));
                s_awid[i*ID_W +: ID_W] = 4'($urandom);
                s_awaddr[i*ADDR_W +: ADDR_W] = $urandom;
                w_left[i] = int'(s_awlen[i*8 +: 8]) + 1;
            end
            if (!s_wvalid[i] && w_left[i] > 0 && $urandom_range(0, 1) == 1) begin
                s_wvalid[i] = 1;
                s_wdata[i*DATA_W +: DATA_W] = $urandom;
                s_wstrb[i*STRB_W +: STRB_W] = 4'($urandom);
                s_wlast[i] = (w_left[i] == 1);
            end
            ar_hs_p[i] = 0; aw_hs_p[i] = 0; w_hs_p[i] = 0;
        end
        m_arready = ($urandom_range(0, 2) != 0);
        m_awready = ($urandom_range(0, 2) != 0);
        m_wready  = ($urandom_range(0, 2) != 0);
        m_rvalid  = $urandom_range(0, 1) == 1;
        m_rid     = rand_resp_id();
        m_rdata   = $urandom;
        s_rready  = 5'($urandom);
        m_bvalid  = $urandom_range(0, 1) == 1;
        m_bid     = rand_resp_id();
        s_bready  = 5'($urandom);
    endtask

    task automatic model_and_check();
        int g, ri, bi;
        logic [N-1:0] e;
        bit av, wv, awh, wh;

        g = (ar_g >= 0) ? ar_g : pick(s_arvalid, rr_ar_m);
        e = '0;
        if (g >= 0) e[g] = m_arready;
        check_output("ar_valid", m_arvalid, g >= 0);
        check_output("ar_ready", s_arready, e);
        if (g >= 0) begin
            check_output("ar_id", m_arid, {3'(g), s_arid[g*ID_W +: ID_W]});
            check_output("ar_addr", m_araddr, s_araddr[g*ADDR_W +: ADDR_W]);
            if (m_arready) begin
                ar_hs_p[g] = 1;
                rr_ar_m = (g + 1) % N;
                ar_g = -1;
            end else begin
                ar_g = g;
            end
        end

        g  = (wg >= 0) ? wg : pick(s_awvalid, rr_aw_m);
        av = (g >= 0) && !aw_d;
        wv = (g >= 0) && !w_d && s_wvalid[g];
        check_output("aw_valid", m_awvalid, av);
        check_output("w_valid", m_wvalid, wv);
        e = '0;
        if (av) e[g] = m_awready;
        check_output("aw_ready", s_awready, e);
        e = '0;
        if (g >= 0 && !w_d) e[g] = m_wready;
        check_output("w_ready", s_wready, e);
        if (av) begin
            check_output("aw_id", m_awid, {3'(g), s_awid[g*ID_W +: ID_W]});
            check_output("aw_addr", m_awaddr, s_awaddr[g*ADDR_W +: ADDR_W]);
            check_output("aw_len", m_awlen, s_awlen[g*8 +: 8]);
        end
        if (wv) begin
            check_output("w_data", m_wdata, s_wdata[g*DATA_W +: DATA_W]);
            check_output("w_strb", m_wstrb, s_wstrb[g*STRB_W +: STRB_W]);
            check_output("w_last", m_wlast, s_wlast[g]);
        end
        if (g >= 0) begin
            if (wg < 0) rr_aw_m = (g + 1) % N;
            awh = av && m_awready;
            wh  = wv && m_wready;
            aw_hs_p[g] = awh;
            w_hs_p[g]  = wh;
            aw_d = aw_d || awh;
            w_d  = w_d || (wh && s_wlast[g]);
            if (aw_d && w_d) begin
                wg = -1; aw_d = 0; w_d = 0;
            end else begin
                wg = g;
            end
        end

        ri = int'(m_rid[MID_W-1:ID_W]);
        e = '0;
        if (ri < N) e[ri] = m_rvalid;
        check_output("r_valid", s_rvalid, e);
        if (ri < N) begin
            check_output("r_ready", m_rready, s_rready[ri]);
            check_output("r_id", s_rid[ri*ID_W +: ID_W], m_rid[ID_W-1:0]);
            check_output("r_data", s_rdata[ri*DATA_W +: DATA_W], m_rdata);
        end else begin
            check_output("r_ready_drop", m_rready, 1);
        end

        bi = int'(m_bid[MID_W-1:ID_W]);
        e = '0;
        if (bi < N) e[bi] = m_bvalid;
        check_output("b_valid", s_bvalid, e);
        if (bi < N) begin
            check_output("b_ready", m_bready, s_bready[bi]);
            check_output("b_id", s_bid[bi*ID_W +: ID_W], m_bid[ID_W-1:0]);
        end else begin
            check_output("b_ready_drop", m_bready, 1);
        end

        check_output("decode_err", decode_err, dec_m);
        dec_m = dec_m || (m_rvalid && ri >= N) || (m_bvalid && bi >= N);
    endtask

    initial begin
        drive_idle();
        model_reset();
        #12;
        s_arvalid = '1; s_awvalid = '1; s_wvalid = '1;
        m_arready = 1; m_awready = 1; m_wready = 1;
        m_rvalid = 1; m_bvalid = 1; s_rready = '1; s_bready = '1;
        #1;
        check_output("rst_ar_valid", m_arvalid, 0);
        check_output("rst_ar_ready", s_arready, 0);
        check_output("rst_aw_valid", m_awvalid, 0);
        check_output("rst_aw_ready", s_awready, 0);
        check_output("rst_w_valid", m_wvalid, 0);
        check_output("rst_w_ready", s_wready, 0);
        check_output("rst_r_valid", s_rvalid, 0);
        check_output("rst_r_ready", m_rready, 0);
        check_output("rst_b_valid", s_bvalid, 0);
        check_output("rst_b_ready", m_bready, 0);
        check_output("rst_decode", decode_err, 0);

        // Fairness: every master requesting, downstream always ready.
        drive_idle();
        for (int i = 0; i < N; i++) s_araddr[i*ADDR_W +: ADDR_W] = 32'h1000_0000 + i;
        s_arvalid = '1;
        m_arready = 1;
        @(negedge clock);
        reset = 1;
        #1;
        for (int k = 0; k < 6; k++) begin
            check_output("fair_valid", m_arvalid, 1);
            check_output("fair_idx", m_arid[MID_W-1:ID_W], k % N);
            @(negedge clock);
        end

        // Lock under backpressure: master 2 keeps the bus while master 0 waits.
        s_arvalid = '0;
        m_arready = 0;
        s_araddr[2*ADDR_W +: ADDR_W] = 32'hA2A2_0002;
        s_arvalid[2] = 1;
        #1;
        check_output("lock_first", m_araddr, 32'hA2A2_0002);
        @(posedge clock);
        #1;
        s_arvalid[0] = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            check_output("lock_hold", m_araddr, 32'hA2A2_0002);
            check_output("lock_ready", s_arready, 0);
        end
        m_arready = 1;
        #1;
        check_output("lock_hs_addr", m_araddr, 32'hA2A2_0002);
        check_output("lock_hs_ready", s_arready, 5'b00100);
        @(posedge clock);
        #1;
        s_arvalid[2] = 0;
        @(negedge clock);
        check_output("lock_next_idx", m_arid[MID_W-1:ID_W], 0);
        check_output("lock_next_addr", m_araddr, 32'h1000_0000);

        // Randomized traffic from a fresh reset.
        @(posedge clock);
        #1;
        reset = 0;
        drive_idle();
        model_reset();
        @(negedge clock);
        reset = 1;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clock);
            #1;
            apply_stimulus();
            @(negedge clock);
            model_and_check();
        end

        // Reset in the middle of a write burst while every channel is active.
        @(posedge clock);
        #1;
        drive_idle();
        reset = 0;
        @(negedge clock);
        reset = 1;
        s_awvalid[1] = 1;
        s_awlen[15:8] = 8'd3;
        s_awid[7:4] = 4'h5;
        s_wvalid[1] = 1;
        m_awready = 1; m_wready = 1;
        s_arvalid[3] = 1;
        m_rvalid = 1; m_rid = {3'd1, 4'h2}; s_rready = '1;
        m_bvalid = 1; m_bid = {3'd2, 4'h1}; s_bready = '1;
        @(posedge clock);
        @(posedge clock);
        #2;
        reset = 0;
        #1;
        check_output("mid_aw_valid", m_awvalid, 0);
        check_output("mid_aw_ready", s_awready, 0);
        check_output("mid_w_valid", m_wvalid, 0);
        check_output("mid_w_ready", s_wready, 0);
        check_output("mid_ar_valid", m_arvalid, 0);
        check_output("mid_ar_ready", s_arready, 0);
        check_output("mid_r_valid", s_rvalid, 0);
        check_output("mid_r_ready", m_rready, 0);
        check_output("mid_b_valid", s_bvalid, 0);
        check_output("mid_b_ready", m_bready, 0);
        s_awvalid[0] = 1;
        s_wvalid[1] = 0;
        @(negedge clock);
        reset = 1;
        #1;
        check_output("post_rst_aw_valid", m_awvalid, 1);
        check_output("post_rst_aw_idx", m_awid[MID_W-1:ID_W], 0);

        // Directed response routing and the sticky decode error.
        @(posedge clock);
        #1;
        drive_idle();
        m_rvalid = 1;
        m_rid = {3'd3, 4'hA};
        s_rready = 5'b01000;
        #1;
        check_output("route_r_valid", s_rvalid, 5'b01000);
        check_output("route_r_id", s_rid[3*ID_W +: ID_W], 4'hA);
        check_output("route_r_ready", m_rready, 1);
        s_rready = 5'b10111;
        #1;
        check_output("route_r_ready_low", m_rready, 0);
        check_output("decode_clear", decode_err, 0);
        m_rvalid = 0;
        m_bvalid = 1;
        m_bid = {3'd5, 4'h3};
        s_bready = '0;
        #1;
        check_output("oor_b_ready", m_bready, 1);
        check_output("oor_b_valid", s_bvalid, 0);
        @(posedge clock);
        #1;
        check_output("oor_decode_set", decode_err, 1);
        m_bvalid = 0;
        @(posedge clock);
        #1;
        check_output("oor_decode_sticky", decode_err, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axi_master_arbiter.md
# axi_master_arbiter

Parametrised N-to-1 AXI4 master arbiter placed between several CPU/DMA master ports and the single MAXI port of the SoC top. It lets a multi-core top share one external AXI bus. Read and write address channels use independent round-robin arbitration. Master index bits are prefixed onto transaction IDs so R and B responses route back without reorder buffers. The W channel is locked to the current write-address winner until its last beat.

## Interface
Parameters:
- N_MST, 2: number of upstream masters, 2..8.
- ID_W, 4: upstream ID width.
- ADDR_W, 32: address width.
- DATA_W, 64: data width; strobe width is DATA_W/8.
- IDX_W, $clog2(N_MST): master-index width. Downstream ID width is ID_W+IDX_W.

Ports:
- clock  in  1  single clock.
- reset  in  1  asynchronous, active-low reset.
- s_aw{id,addr,len,size,burst,valid}  in  N_MST×field  upstream AW, flattened, master 0 in the LSBs; s_awready  out  N_MST.
- s_w{data,strb,last,valid}  in  N_MST×field  upstream W; s_wready  out  N_MST.
- s_b{id,resp,valid}  out  N_MST×field; s_bready  in  N_MST.
- s_ar{id,addr,len,size,burst,valid}  in  N_MST×field; s_arready  out  N_MST.
- s_r{id,data,resp,last,valid}  out  N_MST×field; s_rready  in  N_MST.
- m_aw*, m_w*, m_b*, m_ar*, m_r*  standard AXI4 downstream channels, same fields; id width ID_W+IDX_W.
- decode_err  out  1  sticky; set when a response arrives with an ID index ≥ N_MST.

## Operation
- ID mapping: m_arid/m_awid = {index, s_id}. The response index is id[ID_W+IDX_W-1:ID_W]; the upstream id is the low ID_W bits.
- AR arbiter has states AR_IDLE and AR_LOCK.
  - AR_IDLE: the winner is the first valid master at or after rr_ar, wrapping modulo N_MST. The winner drives m_ar combinationally in the same cycle.
  - If the handshake completes, stay in AR_IDLE. Otherwise go to AR_LOCK holding the winner index, which keeps AXI valid stable.
  - AR_LOCK: forward only the locked master. Return to AR_IDLE on the m_ar handshake.
  - On every AR handshake, rr_ar ← winner+1, wrapping N_MST-1 → 0.
  - Only the granted master sees s_arready = m_arready; all other masters see 0.
- R routing: s_rvalid[idx] = m_rvalid, and all others are 0; m_rready = s_rready[idx]. Multiple outstanding reads are allowed and are unlimited.
- Write FSM states are W_IDLE, W_BUSY(widx, aw_done, w_done).
  - W_IDLE: pick the RR winner on s_awvalid and forward its AW in the same cycle.
  - On entering W_BUSY: forward AW until handshake, then set aw_done.
  - In parallel, forward W (s_w* ↔ m_w*) from widx only; set w_done on the handshake with wlast.
  - Return to W_IDLE when both aw_done and w_done are set, including when both are set in the same cycle.
  - rr_aw advances on grant.
  - W data before AW acceptance is legal and is forwarded.
  - No new AW grant is made while in W_BUSY; m_awvalid=0 after aw_done.
- B routing: same rule as R.
- Out-of-range response index: assert m_rready/m_bready = 1, drop the beat, and set decode_err. decode_err is cleared only by reset.

## Timing
- Arbitration and forwarding paths are zero-latency and combinational. Only grant/lock/FSM/rr/decode_err are registered.
- The m_ar/m_aw throughput is one handshake per cycle when m_*ready is held high. For AW, the next grant comes after the previous burst's W completes.
- Reset is asynchronous, asserted low, with all state cleared immediately:
  - all *valid and *ready outputs are 0 except the combinational pass-through of m_*ready for an idle master (none granted, so 0);
  - rr_ar = rr_aw = 0;
  - FSMs idle;
  - decode_err = 0.
- Reset mid-burst abandons the burst. No partial completion is reported upstream.
- Simultaneous R and B responses to the same master are independent channels with no interaction.
- A grant is never revoked while valid is held, whatever higher-priority requests arrive.

## Test plan
- Fairness: N_MST=4, all s_arvalid high, m_arready=1 → m_arid index sequence 0,1,2,3,0 over 5 cycles.
- Lock under backpressure: master 2 wins, m_arready=0 for 3 cycles, master 0 raises valid → m_araddr stays master 2's until the handshake; master 0 is granted next.
- Write lock: master 1 issues AW len=3, then master 0 issues AW. Expected: m_awvalid stays 0 for master 0 until master 1's 4th beat with wlast is accepted. Master 0's W beats see s_wready=0 throughout.
- W before AW: master 0 presents W len=0 with wlast two cycles before m_awready rises → the W beat passes, and the FSM returns to idle the cycle after the AW handshake.
- Response routing: m_rid={2'd3,4'hA}, m_rvalid=1 → only s_rvalid[3]=1 with s_rid=4'hA. m_bid index 5 with N_MST=5 → m_bready=1, no s_bvalid, decode_err=1.
- Reset mid-operation: drop reset low during W_BUSY beat 2 → all valid/ready outputs are 0 in the same cycle; after release, master 0 wins first.
